// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502 status register: flag bit positions,
// flag instruction encodings and the P image packing helper.
package status_reg_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  typedef enum logic [2:0] {
    FLAG_NOP = 3'd0,
    FLAG_CLC = 3'd1,
    FLAG_SEC = 3'd2,
    FLAG_CLI = 3'd3,
    FLAG_SEI = 3'd4,
    FLAG_CLD = 3'd5,
    FLAG_SED = 3'd6,
    FLAG_CLV = 3'd7
  } flag_op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  // B is not stored; the caller supplies it (0 for p_reg, push_brk for pushes).
  function automatic logic [7:0] pack_p(input flags_t f, input logic b);
    logic [7:0] p;
    p         = '0;
    p[FLAG_C] = f.c;
    p[FLAG_Z] = f.z;
    p[FLAG_I] = f.i;
    p[FLAG_D] = f.d;
    p[FLAG_B] = b;
    p[FLAG_U] = 1'b1;
    p[FLAG_V] = f.v;
    p[FLAG_N] = f.n;
    return p;
  endfunction

endpackage

// File: rtl/status_reg.sv
// 6502 processor status register: latches ALU flags, flag instructions,
// BIT, PLP/RTI loads and interrupt entry; gates IRQ at instruction bounds.
module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0] RESET_P    = 8'h24,
  parameter bit         DECIMAL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_Y,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic       nz_update,
  input  logic       c_update,
  input  logic       v_update,
  input  logic       bit_update,
  input  logic [7:0] mem_data,
  input  logic       p_load,
  input  logic [2:0] flag_op,
  input  logic       irq_entry,
  input  logic       push_brk,
  input  logic       instr_done,
  output logic [7:0] p_reg,
  output logic [7:0] p_push,
  output logic       carry_flag,
  output logic       decimal_flag,
  output logic       irq_inhibit
);

  flags_t flags;
  flags_t flags_nxt;
  logic   alu_zero;

  // PLP/RTI pull B and U from the stack but neither is a real flop.
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data[FLAG_U:FLAG_B];

  assign alu_zero = (alu_Y == 8'h00);

  // Sources applied lowest priority first so later assignments win per flag.
  always_comb begin
    flags_nxt = flags;

    if (nz_update) begin
      flags_nxt.n = alu_Y[7];
      flags_nxt.z = alu_zero;
    end
    if (c_update) flags_nxt.c = alu_carry_out;
    if (v_update) flags_nxt.v = alu_overflow;

    if (bit_update) begin
      flags_nxt.n = mem_data[7];
      flags_nxt.v = mem_data[6];
      flags_nxt.z = alu_zero;
    end

    case (flag_op_e'(flag_op))
      FLAG_CLC: flags_nxt.c = 1'b0;
      FLAG_SEC: flags_nxt.c = 1'b1;
      FLAG_CLI: flags_nxt.i = 1'b0;
      FLAG_SEI: flags_nxt.i = 1'b1;
      FLAG_CLD: flags_nxt.d = 1'b0;
      FLAG_SED: flags_nxt.d = 1'b1;
      FLAG_CLV: flags_nxt.v = 1'b0;
      default:  ;
    endcase

    if (irq_entry) flags_nxt.i = 1'b1;

    if (p_load) begin
      flags_nxt.n = mem_data[FLAG_N];
      flags_nxt.v = mem_data[FLAG_V];
      flags_nxt.d = mem_data[FLAG_D];
      flags_nxt.i = mem_data[FLAG_I];
      flags_nxt.z = mem_data[FLAG_Z];
      flags_nxt.c = mem_data[FLAG_C];
    end

    if (!DECIMAL_EN) flags_nxt.d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags.n <= RESET_P[FLAG_N];
      flags.v <= RESET_P[FLAG_V];
      flags.d <= RESET_P[FLAG_D] & DECIMAL_EN;
      flags.i <= RESET_P[FLAG_I];
      flags.z <= RESET_P[FLAG_Z];
      flags.c <= RESET_P[FLAG_C];
    end else begin
      flags <= flags_nxt;
    end
  end

  // I as seen by the interrupt logic lags by one instruction (CLI/SEI delay).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_inhibit <= 1'b1;
    end else if (instr_done) begin
      irq_inhibit <= flags_nxt.i;
    end
  end

  assign p_reg        = pack_p(flags, 1'b0);
  assign p_push       = pack_p(flags, push_brk);
  assign carry_flag   = flags.c;
  assign decimal_flag = flags.d;

endmodule
